// File: rtl/serdes_bridge.sv
// serdes_bridge: bit-serial <-> parallel bridge for the FIR datapath.
//   RX: assembles DATA_WIDTH words from LANES-wide beats and queues them in a
//       FIFO_DEPTH-entry word FIFO toward the FIR input.
//   TX: takes FIR output words and shifts them out LANES bits per beat under
//       receiver flow control, with no bubble between back-to-back words.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_en                          global enable (low freezes all state)
//   i_din, i_din_valid, o_ready   RX serial beat handshake
//   o_word, o_word_valid,
//   i_word_ready, o_rx_count      RX FIFO head, pop handshake, occupancy
//   i_word, i_word_valid,
//   o_word_ready                  TX word handshake
//   o_dout, o_dout_valid, i_ready TX serial beat handshake
module serdes_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 1,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic [LANES-1:0]              i_din,
  input  logic                          i_din_valid,
  output logic                          o_ready,
  output logic [DATA_WIDTH-1:0]         o_word,
  output logic                          o_word_valid,
  input  logic                          i_word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_count,
  input  logic [DATA_WIDTH-1:0]         i_word,
  input  logic                          i_word_valid,
  output logic                          o_word_ready,
  output logic [LANES-1:0]              o_dout,
  output logic                          o_dout_valid,
  input  logic                          i_ready
);

  localparam int unsigned BEATS = DATA_WIDTH / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned PW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Bit offset of the lane group carried by beat k.
  function automatic logic [PW-1:0] lane_pos(input logic [BW-1:0] k);
    if (MSB_FIRST != 0) return PW'((BEATS - 1 - 32'(k)) * LANES);
    else                return PW'(32'(k) * LANES);
  endfunction

  // ---------------------------------------------------------------- RX path
  logic [BW-1:0]         rx_beat;
  logic [DATA_WIDTH-1:0] rx_buf;
  logic [DATA_WIDTH-1:0] rx_merged;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  rx_accept;
  logic                  push;
  logic                  pop;

  assign o_ready      = (count != CW'(FIFO_DEPTH));
  assign o_word_valid = (count != '0);
  assign o_word       = mem[rd_ptr];
  assign o_rx_count   = count;

  assign rx_accept = i_en && i_din_valid && o_ready;
  assign push      = rx_accept && (rx_beat == LAST_BEAT);
  assign pop       = i_en && o_word_valid && i_word_ready;

  // Partial word with the incoming beat merged in; pushed whole on the last beat.
  always_comb begin
    rx_merged = rx_buf;
    rx_merged[lane_pos(rx_beat) +: LANES] = i_din;
  end

  // Beat assembly and word FIFO.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_beat <= '0;
      rx_buf  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (rx_accept) begin
        rx_buf  <= rx_merged;
        rx_beat <= push ? '0 : rx_beat + BW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= rx_merged;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // ---------------------------------------------------------------- TX path
  typedef enum logic {IDLE, SHIFT} tx_state_t;

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [BW-1:0]         tx_beat;
  logic                  tx_last;

  // Final beat being consumed this cycle: the next word may be taken in its place.
  assign tx_last      = (state == SHIFT) && i_ready && (tx_beat == LAST_BEAT);
  assign o_word_ready = (state == IDLE) || tx_last;

  // TX FSM: load, shift on i_ready, reload without a bubble on the final beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      tx_word      <= '0;
      tx_beat      <= '0;
      o_dout       <= '0;
      o_dout_valid <= 1'b0;
    end else if (i_en) begin
      case (state)
        IDLE: begin
          if (i_word_valid) begin
            tx_word      <= i_word;
            tx_beat      <= '0;
            o_dout       <= i_word[lane_pos(BW'(0)) +: LANES];
            o_dout_valid <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_ready) begin
            if (tx_beat == LAST_BEAT) begin
              if (i_word_valid) begin
                tx_word <= i_word;
                tx_beat <= '0;
                o_dout  <= i_word[lane_pos(BW'(0)) +: LANES];
              end else begin
                o_dout_valid <= 1'b0;
                state        <= IDLE;
              end
            end else begin
              tx_beat <= tx_beat + BW'(1);
              o_dout  <= tx_word[lane_pos(tx_beat + BW'(1)) +: LANES];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_bridge.sv
// Testbench for serdes_bridge: two instances (LSB-first and MSB-first,
// DATA_WIDTH=8, LANES=2, FIFO_DEPTH=4) share the same stimulus.
module tb_serdes_bridge;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] din;
  logic       din_valid;
  logic       word_ready_in;
  logic [7:0] word_in;
  logic       word_valid_in;
  logic       ready_in;

  logic       ready_o      [2];
  logic [7:0] word_o       [2];
  logic       word_valid_o [2];
  logic [2:0] count_o      [2];
  logic       word_ready_o [2];
  logic [1:0] dout_o       [2];
  logic       dout_valid_o [2];

  // Index 0: LSB lane group first, index 1: MSB lane group first.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    serdes_bridge #(
      .DATA_WIDTH(8), .LANES(2), .MSB_FIRST(g), .FIFO_DEPTH(4)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_din       (din),
      .i_din_valid (din_valid),
      .o_ready     (ready_o[g]),
      .o_word      (word_o[g]),
      .o_word_valid(word_valid_o[g]),
      .i_word_ready(word_ready_in),
      .o_rx_count  (count_o[g]),
      .i_word      (word_in),
      .i_word_valid(word_valid_in),
      .o_word_ready(word_ready_o[g]),
      .o_dout      (dout_o[g]),
      .o_dout_valid(dout_valid_o[g]),
      .i_ready     (ready_in)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got 0x%0h, expected 0x%0h", name, idx, $time, act, exp);
    end
  endtask

  // seq packs beats b0..b3 with b0 in the top two bits.
  function automatic logic [1:0] beat_of(input logic [7:0] seq, input int k);
    logic [7:0] t;
    t = seq >> (6 - 2 * k);
    return t[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; din = '0; din_valid = 1'b0; word_ready_in = 1'b0;
    word_in = '0; word_valid_in = 1'b0; ready_in = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int g = 0; g < 2; g++) begin
      check({tag, "_ready"},      g, 32'(ready_o[g]),      32'd1);
      check({tag, "_word"},       g, 32'(word_o[g]),       32'd0);
      check({tag, "_word_valid"}, g, 32'(word_valid_o[g]), 32'd0);
      check({tag, "_rx_count"},   g, 32'(count_o[g]),      32'd0);
      check({tag, "_word_ready"}, g, 32'(word_ready_o[g]), 32'd1);
      check({tag, "_dout"},       g, 32'(dout_o[g]),       32'd0);
      check({tag, "_dout_valid"}, g, 32'(dout_valid_o[g]), 32'd0);
    end
  endtask

  // seq: beat sequence / TX word; rev: the same value with lane groups reversed,
  // i.e. the word an LSB-first receiver builds from seq, or the LSB-first beat order.
  typedef struct packed {
    logic [7:0] seq;
    logic [7:0] rev;
  } vec_t;

  localparam int NV = 6;
  vec_t tab [NV];

  // Reference model state for the random phase.
  logic [15:0] fifo_q [$];   // {msb_first_word, lsb_first_word}
  logic [1:0]  rx_beats [$];
  logic [3:0]  tx_q [$];     // {msb_first_beat, lsb_first_beat}
  logic [1:0]  last_dout [2];

  task automatic model_load(input logic [7:0] w);
    logic [7:0] a;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      a = w >> (2 * k);
      b = w >> (6 - 2 * k);
      tx_q.push_back({b[1:0], a[1:0]});
    end
  endtask

  initial begin
    logic [7:0]  pat;
    logic [15:0] head;
    logic [3:0]  tb_beat;
    logic [7:0]  lw;
    logic [7:0]  mw;
    int          k;
    int          pop_pct;
    bit          exp_ready;
    bit          exp_dv;
    bit          exp_wr;

    n_checks = 0;
    n_fail   = 0;
    tab[0] = '{seq: 8'h1B, rev: 8'hE4};
    tab[1] = '{seq: 8'hE4, rev: 8'h1B};
    tab[2] = '{seq: 8'hB1, rev: 8'h4E};
    tab[3] = '{seq: 8'hC6, rev: 8'h93};
    tab[4] = '{seq: 8'h00, rev: 8'h00};
    tab[5] = '{seq: 8'h3A, rev: 8'hAC};

    idle_inputs();
    rst = 1'b1;
    #12;
    check_reset_vals("por");
    tick();
    rst = 1'b0;
    tick();

    // RX table: one word per vector, checked one cycle after the last beat, then popped.
    for (int v = 0; v < NV; v++) begin
      word_ready_in = 1'b0;
      din_valid     = 1'b1;
      for (int b = 0; b < 4; b++) begin
        din = beat_of(tab[v].seq, b);
        tick();
        if (b == 2)
          for (int g = 0; g < 2; g++) check("rx_early_valid", g, 32'(word_valid_o[g]), 32'd0);
      end
      din_valid = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
        check("rx_valid", g, 32'(word_valid_o[g]), 32'd1);
        check("rx_count1", g, 32'(count_o[g]), 32'd1);
      end
      check("rx_word_lsb", 0, 32'(word_o[0]), 32'(tab[v].rev));
      check("rx_word_msb", 1, 32'(word_o[1]), 32'(tab[v].seq));
      word_ready_in = 1'b1;
      tick();
      word_ready_in = 1'b0;
      for (int g = 0; g < 2; g++) begin
        check("rx_count0", g, 32'(count_o[g]), 32'd0);
        check("rx_empty", g, 32'(word_valid_o[g]), 32'd0);
      end
    end

    // TX table: all words back to back with i_ready=1.
    word_valid_in = 1'b1;
    word_in       = tab[0].seq;
    ready_in      = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) check("tx_idle_wr", g, 32'(word_ready_o[g]), 32'd1);
    tick();
    for (int v = 0; v < NV; v++) begin
      for (int b = 0; b < 4; b++) begin
        for (int g = 0; g < 2; g++) begin
          check("tx_b2b_valid", g, 32'(dout_valid_o[g]), 32'd1);
          check("tx_b2b_wr", g, 32'(word_ready_o[g]), 32'(b == 3));
        end
        check("tx_b2b_lsb", 0, 32'(dout_o[0]), 32'(beat_of(tab[v].rev, b)));
        check("tx_b2b_msb", 1, 32'(dout_o[1]), 32'(beat_of(tab[v].seq, b)));
        if (b == 3) begin
          if (v < NV - 1) word_in = tab[v + 1].seq;
          else            word_valid_in = 1'b0;
        end
        tick();
      end
    end
    for (int g = 0; g < 2; g++) begin
      check("tx_b2b_end_valid", g, 32'(dout_valid_o[g]), 32'd0);
      check("tx_b2b_end_wr", g, 32'(word_ready_o[g]), 32'd1);
    end

    // TX stall: i_ready pattern 1,0,0,1,0,1,1,1.
    word_valid_in = 1'b1;
    word_in       = tab[3].seq;
    tick();
    word_valid_in = 1'b0;
    pat = 8'b1110_1001;
    k   = 0;
    for (int c = 0; c < 8 && k < 4; c++) begin
      ready_in = pat[c];
      #1;
      for (int g = 0; g < 2; g++) begin
        check("tx_stall_valid", g, 32'(dout_valid_o[g]), 32'd1);
        check("tx_stall_wr", g, 32'(word_ready_o[g]), 32'(pat[c] && k == 3));
      end
      check("tx_stall_lsb", 0, 32'(dout_o[0]), 32'(beat_of(tab[3].rev, k)));
      check("tx_stall_msb", 1, 32'(dout_o[1]), 32'(beat_of(tab[3].seq, k)));
      tick();
      if (pat[c]) k++;
    end
    ready_in = 1'b0;
    for (int g = 0; g < 2; g++) check("tx_stall_end", g, 32'(dout_valid_o[g]), 32'd0);

    // RX backpressure: four words fill the FIFO, the fifth waits for a pop.
    word_ready_in = 1'b0;
    din_valid     = 1'b1;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) begin
        din = beat_of(tab[w].seq, b);
        tick();
      end
    din = beat_of(tab[4].seq, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int g = 0; g < 2; g++) begin
        check("bp_full_ready", g, 32'(ready_o[g]), 32'd0);
        check("bp_full_count", g, 32'(count_o[g]), 32'd4);
      end
      tick();
    end
    word_ready_in = 1'b1;
    tick();
    word_ready_in = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check("bp_pop_ready", g, 32'(ready_o[g]), 32'd1);
      check("bp_pop_count", g, 32'(count_o[g]), 32'd3);
    end
    for (int b = 0; b < 4; b++) begin
      din = beat_of(tab[4].seq, b);
      tick();
    end
    din_valid = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) check("bp_refill_count", g, 32'(count_o[g]), 32'd4);
    word_ready_in = 1'b1;
    for (int w = 1; w < 5; w++) begin
      #1;
      for (int g = 0; g < 2; g++) check("bp_drain_valid", g, 32'(word_valid_o[g]), 32'd1);
      check("bp_drain_lsb", 0, 32'(word_o[0]), 32'(tab[w].rev));
      check("bp_drain_msb", 1, 32'(word_o[1]), 32'(tab[w].seq));
      tick();
    end
    word_ready_in = 1'b0;
    for (int g = 0; g < 2; g++) check("bp_drain_count", g, 32'(count_o[g]), 32'd0);

    // Enable freeze mid RX word and mid TX word.
    din_valid     = 1'b1;
    din           = beat_of(tab[5].seq, 0);
    word_valid_in = 1'b1;
    word_in       = tab[2].seq;
    ready_in      = 1'b0;
    tick();
    word_valid_in = 1'b0;
    din           = beat_of(tab[5].seq, 1);
    ready_in      = 1'b1;
    tick();
    en = 1'b0; word_ready_in = 1'b1; word_valid_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      din = 2'($urandom);
      tick();
      for (int g = 0; g < 2; g++) begin
        check("en_count", g, 32'(count_o[g]), 32'd0);
        check("en_dvalid", g, 32'(dout_valid_o[g]), 32'd1);
        check("en_wr", g, 32'(word_ready_o[g]), 32'd0);
      end
      check("en_dout_lsb", 0, 32'(dout_o[0]), 32'(beat_of(tab[2].rev, 1)));
      check("en_dout_msb", 1, 32'(dout_o[1]), 32'(beat_of(tab[2].seq, 1)));
    end
    en = 1'b1; word_ready_in = 1'b0; word_valid_in = 1'b0; ready_in = 1'b0;
    din = beat_of(tab[5].seq, 2);
    tick();
    din = beat_of(tab[5].seq, 3);
    tick();
    din_valid = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) check("en_resume_count", g, 32'(count_o[g]), 32'd1);
    check("en_resume_lsb", 0, 32'(word_o[0]), 32'(tab[5].rev));
    check("en_resume_msb", 1, 32'(word_o[1]), 32'(tab[5].seq));
    check("en_tx_hold", 1, 32'(dout_o[1]), 32'(beat_of(tab[2].seq, 1)));

    // Asynchronous reset mid RX word, with a FIFO word queued and TX mid word.
    din_valid = 1'b1;
    din       = beat_of(tab[2].seq, 0);
    tick();
    din_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    tick();
    rst = 1'b0;
    din_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      din = beat_of(tab[3].seq, b);
      tick();
    end
    din_valid = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) check("post_rst_count", g, 32'(count_o[g]), 32'd1);
    check("post_rst_lsb", 0, 32'(word_o[0]), 32'(tab[3].rev));
    check("post_rst_msb", 1, 32'(word_o[1]), 32'(tab[3].seq));
    word_ready_in = 1'b1;
    word_valid_in = 1'b1;
    word_in       = tab[5].seq;
    ready_in      = 1'b1;
    tick();
    word_ready_in = 1'b0;
    word_valid_in = 1'b0;
    for (int b = 0; b < 4; b++) begin
      check("post_rst_tx_lsb", 0, 32'(dout_o[0]), 32'(beat_of(tab[5].rev, b)));
      check("post_rst_tx_msb", 1, 32'(dout_o[1]), 32'(beat_of(tab[5].seq, b)));
      tick();
    end
    for (int g = 0; g < 2; g++) check("post_rst_tx_end", g, 32'(dout_valid_o[g]), 32'd0);

    // Random phase against the queue-based reference model.
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fifo_q.delete();
    rx_beats.delete();
    tx_q.delete();
    last_dout[0] = '0;
    last_dout[1] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pop_pct       = ((cyc / 400) % 2 == 1) ? 15 : 80;
      en            = ($urandom_range(0, 9) != 0);
      din_valid     = ($urandom_range(0, 3) != 0);
      din           = 2'($urandom);
      word_ready_in = ($urandom_range(0, 99) < pop_pct);
      word_valid_in = ($urandom_range(0, 2) != 0);
      word_in       = 8'($urandom);
      ready_in      = ($urandom_range(0, 9) < 7);
      #1;
      exp_ready = (fifo_q.size() != 4);
      exp_dv    = (tx_q.size() != 0);
      exp_wr    = (tx_q.size() == 0) || (ready_in && tx_q.size() == 1);
      for (int g = 0; g < 2; g++) begin
        check("rnd_ready", g, 32'(ready_o[g]), 32'(exp_ready));
        check("rnd_word_valid", g, 32'(word_valid_o[g]), 32'(fifo_q.size() != 0));
        check("rnd_count", g, 32'(count_o[g]), 32'(fifo_q.size()));
        check("rnd_dout_valid", g, 32'(dout_valid_o[g]), 32'(exp_dv));
        check("rnd_word_ready", g, 32'(word_ready_o[g]), 32'(exp_wr));
      end
      if (fifo_q.size() != 0) begin
        head = fifo_q[0];
        check("rnd_word", 0, 32'(word_o[0]), 32'(head[7:0]));
        check("rnd_word", 1, 32'(word_o[1]), 32'(head[15:8]));
      end
      if (exp_dv) begin
        tb_beat = tx_q[0];
        check("rnd_dout", 0, 32'(dout_o[0]), 32'(tb_beat[1:0]));
        check("rnd_dout", 1, 32'(dout_o[1]), 32'(tb_beat[3:2]));
      end else begin
        check("rnd_dout_hold", 0, 32'(dout_o[0]), 32'(last_dout[0]));
        check("rnd_dout_hold", 1, 32'(dout_o[1]), 32'(last_dout[1]));
      end
      if (en) begin
        if (fifo_q.size() != 0 && word_ready_in) void'(fifo_q.pop_front());
        if (din_valid && exp_ready) begin
          rx_beats.push_back(din);
          if (rx_beats.size() == 4) begin
            lw = '0;
            mw = '0;
            for (int b = 0; b < 4; b++) begin
              lw = lw | (8'(rx_beats[b]) << (2 * b));
              mw = mw | (8'(rx_beats[b]) << (6 - 2 * b));
            end
            fifo_q.push_back({mw, lw});
            rx_beats.delete();
          end
        end
        if (tx_q.size() == 0) begin
          if (word_valid_in) model_load(word_in);
        end else if (ready_in) begin
          tb_beat      = tx_q.pop_front();
          last_dout[0] = tb_beat[1:0];
          last_dout[1] = tb_beat[3:2];
          if (tx_q.size() == 0 && word_valid_in) model_load(word_in);
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
